load_store_sequencer: RTL and testbench

//  Initiator for the byte-addressed data memory. Accepts one load/store request at a time from the MIPS

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/load_store_sequencer_if.sv | 37 +++
 rtl/load_extend.sv | 20 ++
 rtl/load_store_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_load_store_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory path: access sizes, sequencer
// states and the size-to-byte-count mapping.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } lss_state_t;

    // The unused 2'b10 encoding behaves as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Request/response handshake plus byte-wide RAM bus of the load/store sequencer.
// slave = sequencer view, master = datapath/memory side view.
interface load_store_sequencer_if #(parameter int MEMORY_SIZE = 512);

    localparam int ADDR_WIDTH = $clog2(MEMORY_SIZE);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/load_extend.sv
// Widens a right-aligned 1/2/4-byte load value to 32 bits, zero- or sign-extended.
module load_extend (
    input  logic [31:0] raw,
    input  logic [2:0]  nbytes,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (nbytes)
            3'd1:    result = is_unsigned ? {24'h000000, raw[7:0]}
                                          : 32'(signed'(raw[7:0]));
            3'd2:    result = is_unsigned ? {16'h0000, raw[15:0]}
                                          : 32'(signed'(raw[15:0]));
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/load_store_sequencer.sv
// Splits one load/store request into big-endian single-byte RAM accesses and
// returns the assembled, extended load data with a one-cycle response pulse.
module load_store_sequencer
    import mips_mem_pkg::*;
#(
    parameter int MEMORY_SIZE = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_sequencer_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(MEMORY_SIZE);
    localparam int AW2        = ADDR_WIDTH + 2;

    lss_state_t            state, state_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [2:0]            nbytes_q, nbytes_nxt;
    logic                  we_q, we_nxt;
    logic                  uns_q, uns_nxt;
    logic [31:0]           sdata_q, sdata_nxt;
    logic [31:0]           asm_q, asm_nxt;
    logic                  rd_pend, rd_pend_nxt;

    logic                  ready_q, ready_nxt;
    logic                  rvalid_q, rvalid_nxt;
    logic [31:0]           rdata_q, rdata_nxt;
    logic                  err_q, err_nxt;
    logic                  rd_en_q, rd_en_nxt;
    logic                  wr_en_q, wr_en_nxt;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_nxt;
    logic [7:0]            mwdata_q, mwdata_nxt;

    logic [2:0]            req_nbytes;
    logic                  req_fire;
    logic                  req_misalign;
    logic [AW2-1:0]        last_addr;
    logic                  req_err;
    logic [31:0]           req_aligned;
    logic [31:0]           asm_shift;
    logic [31:0]           ext_data;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.mem_wr_en  = wr_en_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = mwdata_q;

    // Acceptance-time checks; the range test uses the last byte so nothing wraps.
    always_comb begin
        req_nbytes   = size_bytes(bus.req_size);
        req_fire     = bus.req_valid && ready_q;
        req_misalign = ((req_nbytes == 3'd2) && bus.req_addr[0]) ||
                       ((req_nbytes == 3'd4) && (bus.req_addr[1:0] != 2'b00));
        last_addr    = {2'b00, bus.req_addr} + AW2'(req_nbytes) - AW2'(1);
        req_err      = req_misalign || (last_addr >= AW2'(MEMORY_SIZE));
        case (req_nbytes)
            3'd1:    req_aligned = {bus.req_wdata[7:0], 24'h000000};
            3'd2:    req_aligned = {bus.req_wdata[15:0], 16'h0000};
            default: req_aligned = bus.req_wdata;
        endcase
        asm_shift = {asm_q[23:0], bus.mem_rdata};
    end

    load_extend u_load_extend (
        .raw         (asm_shift),
        .nbytes      (nbytes_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        nbytes_nxt  = nbytes_q;
        we_nxt      = we_q;
        uns_nxt     = uns_q;
        sdata_nxt   = sdata_q;
        asm_nxt     = rd_pend ? asm_shift : asm_q;
        rd_pend_nxt = rd_en_q;
        ready_nxt   = ready_q;
        rvalid_nxt  = 1'b0;
        rdata_nxt   = rdata_q;
        err_nxt     = err_q;
        rd_en_nxt   = 1'b0;
        wr_en_nxt   = 1'b0;
        maddr_nxt   = maddr_q;
        mwdata_nxt  = mwdata_q;

        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (req_fire) begin
                    ready_nxt  = 1'b0;
                    we_nxt     = bus.req_we;
                    uns_nxt    = bus.req_unsigned;
                    nbytes_nxt = req_nbytes;
                    cnt_nxt    = 3'd0;
                    asm_nxt    = 32'h0;
                    if (req_err) begin
                        state_nxt  = RESP;
                        rvalid_nxt = 1'b1;
                        err_nxt    = 1'b1;
                        rdata_nxt  = 32'h0;
                    end else begin
                        state_nxt = ACCESS;
                        maddr_nxt = bus.req_addr;
                        if (bus.req_we) begin
                            wr_en_nxt  = 1'b1;
                            mwdata_nxt = req_aligned[31:24];
                            sdata_nxt  = req_aligned << 8;
                        end else begin
                            rd_en_nxt = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt == nbytes_q - 3'd1) begin
                    if (we_q) begin
                        state_nxt  = RESP;
                        rvalid_nxt = 1'b1;
                        err_nxt    = 1'b0;
                        rdata_nxt  = 32'h0;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else begin
                    cnt_nxt   = cnt + 3'd1;
                    maddr_nxt = maddr_q + ADDR_WIDTH'(1);
                    if (we_q) begin
                        wr_en_nxt  = 1'b1;
                        mwdata_nxt = sdata_q[31:24];
                        sdata_nxt  = sdata_q << 8;
                    end else begin
                        rd_en_nxt = 1'b1;
                    end
                end
            end
            // Final byte is on mem_rdata now; fold it in while forming the result.
            DRAIN: begin
                state_nxt  = RESP;
                rvalid_nxt = 1'b1;
                err_nxt    = 1'b0;
                rdata_nxt  = ext_data;
            end
            RESP: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            nbytes_q <= 3'd1;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            sdata_q  <= 32'h0;
            asm_q    <= 32'h0;
            rd_pend  <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            nbytes_q <= nbytes_nxt;
            we_q     <= we_nxt;
            uns_q    <= uns_nxt;
            sdata_q  <= sdata_nxt;
            asm_q    <= asm_nxt;
            rd_pend  <= rd_pend_nxt;
            ready_q  <= ready_nxt;
            rvalid_q <= rvalid_nxt;
            rdata_q  <= rdata_nxt;
            err_q    <= err_nxt;
            rd_en_q  <= rd_en_nxt;
            wr_en_q  <= wr_en_nxt;
            maddr_q  <= maddr_nxt;
            mwdata_q <= mwdata_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer against a 1-cycle-latency byte RAM model.
module tb_load_store_sequencer;
    import mips_mem_pkg::*;

    localparam int MEMORY_SIZE = 512;
    localparam int AW          = $clog2(MEMORY_SIZE);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } strobe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    load_store_sequencer_if #(.MEMORY_SIZE(MEMORY_SIZE)) bus();
    load_store_sequencer #(.MEMORY_SIZE(MEMORY_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [MEMORY_SIZE];
    strobe_t    log_q[$];
    int         both_cnt = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEMORY_SIZE; i++) mem[i] <= 8'h00;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_wr_en || bus.mem_rd_en)
            log_q.push_back('{we: bus.mem_wr_en, addr: bus.mem_addr, data: bus.mem_wdata});
        if (bus.mem_wr_en && bus.mem_rd_en) both_cnt <= both_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Latency is counted in clock edges after the acceptance edge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [AW-1:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_unsigned = ~uns;
        bus.req_addr     = ~addr;
        bus.req_wdata    = ~wdata;
        check("ready_low_after_accept", 32'(bus.req_ready), 32'h0);
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_seen", 32'(bus.resp_valid), 32'h1);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clk);
        #1;
        check("resp_one_cycle", 32'(bus.resp_valid), 32'h0);
        check("ready_back", 32'(bus.req_ready), 32'h1);
    endtask

    int          lat;
    int          base;
    int          seen;
    logic [31:0] rd;
    logic        er;
    logic [7:0]  sw_bytes [4];
    strobe_t     e;

    initial begin
        sw_bytes[0] = 8'hDE; sw_bytes[1] = 8'hAD; sw_bytes[2] = 8'hBE; sw_bytes[3] = 8'hEF;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SIZE_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_err", 32'(bus.resp_err), 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_strobes", {30'h0, bus.mem_rd_en, bus.mem_wr_en}, 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        mem_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // sw 0x10 <- DEADBEEF
        base = log_q.size();
        do_req(1'b1, SIZE_WORD, 1'b0, AW'(16), 32'hDEADBEEF, lat, rd, er);
        check("sw_latency", 32'(lat), 32'd4);
        check("sw_err", 32'(er), 32'h0);
        check("sw_rdata", rd, 32'h0);
        check("sw_nstrobes", 32'(log_q.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            e = log_q[base + k];
            check("sw_strobe", 32'(e), 32'({1'b1, AW'(16 + k), sw_bytes[k]}));
        end

        // lw 0x10
        base = log_q.size();
        do_req(1'b0, SIZE_WORD, 1'b0, AW'(16), 32'h0, lat, rd, er);
        check("lw_latency", 32'(lat), 32'd5);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", 32'(er), 32'h0);
        check("lw_nstrobes", 32'(log_q.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            e = log_q[base + k];
            check("lw_strobe", 32'({e.we, e.addr}), 32'({1'b0, AW'(16 + k)}));
        end

        // lb / lbu 0x11 (0xAD)
        do_req(1'b0, SIZE_BYTE, 1'b0, AW'(17), 32'h0, lat, rd, er);
        check("lb_latency", 32'(lat), 32'd2);
        check("lb_rdata", rd, 32'hFFFFFFAD);
        do_req(1'b0, SIZE_BYTE, 1'b1, AW'(17), 32'h0, lat, rd, er);
        check("lbu_rdata", rd, 32'h000000AD);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", bus.resp_rdata, 32'h000000AD);

        // lh 0x13 misaligned
        base = log_q.size();
        do_req(1'b0, SIZE_HALF, 1'b0, AW'(19), 32'h0, lat, rd, er);
        check("lh_mis_latency", 32'(lat), 32'd0);
        check("lh_mis_err", 32'(er), 32'h1);
        check("lh_mis_rdata", rd, 32'h0);
        check("lh_mis_nstrobes", 32'(log_q.size() - base), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("err_hold", 32'(bus.resp_err), 32'h1);

        // lw 0x1FE out of range / misaligned
        base = log_q.size();
        do_req(1'b0, SIZE_WORD, 1'b0, AW'(510), 32'h0, lat, rd, er);
        check("lw_1fe_err", 32'(er), 32'h1);
        check("lw_1fe_nstrobes", 32'(log_q.size() - base), 32'd0);

        // last word of memory is legal
        do_req(1'b1, SIZE_BYTE, 1'b0, AW'(511), 32'hFFFFFF80, lat, rd, er);
        check("sb_latency", 32'(lat), 32'd1);
        do_req(1'b0, SIZE_WORD, 1'b0, AW'(508), 32'h0, lat, rd, er);
        check("lw_top_err", 32'(er), 32'h0);
        check("lw_top_rdata", rd, 32'h00000080);

        // sh 0x20 only writes two bytes
        do_req(1'b1, SIZE_BYTE, 1'b0, AW'(34), 32'h0000005A, lat, rd, er);
        base = log_q.size();
        do_req(1'b1, SIZE_HALF, 1'b0, AW'(32), 32'h1234ABCD, lat, rd, er);
        check("sh_latency", 32'(lat), 32'd2);
        check("sh_nstrobes", 32'(log_q.size() - base), 32'd2);
        e = log_q[base];
        check("sh_strobe0", 32'(e), 32'({1'b1, AW'(32), 8'hAB}));
        e = log_q[base + 1];
        check("sh_strobe1", 32'(e), 32'({1'b1, AW'(33), 8'hCD}));
        check("sh_mem22_untouched", 32'(mem[34]), 32'h5A);
        do_req(1'b0, SIZE_HALF, 1'b0, AW'(32), 32'h0, lat, rd, er);
        check("lh_latency", 32'(lat), 32'd3);
        check("lh_rdata", rd, 32'hFFFFABCD);
        do_req(1'b0, SIZE_HALF, 1'b1, AW'(32), 32'h0, lat, rd, er);
        check("lhu_rdata", rd, 32'h0000ABCD);

        // size 2'b10 behaves as a word
        do_req(1'b0, 2'b10, 1'b0, AW'(16), 32'h0, lat, rd, er);
        check("size10_latency", 32'(lat), 32'd5);
        check("size10_rdata", rd, 32'hDEADBEEF);

        // reset during the second write cycle of a store
        base = log_q.size();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SIZE_WORD;
        bus.req_addr  = AW'(64);
        bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_strobes", {30'h0, bus.mem_rd_en, bus.mem_wr_en}, 32'h0);
        check("rst_mid_ready", 32'(bus.req_ready), 32'h1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("rst_mid_no_resp", 32'(seen), 32'h0);
        check("rst_mid_nstrobes", 32'(log_q.size() - base), 32'd2);
        check("rst_mid_mem40", 32'(mem[64]), 32'h11);
        check("rst_mid_mem41", 32'(mem[65]), 32'h22);
        check("rst_mid_mem42", 32'(mem[66]), 32'h00);
        do_req(1'b0, SIZE_BYTE, 1'b1, AW'(65), 32'h0, lat, rd, er);
        check("after_rst_lbu", rd, 32'h00000022);

        check("rd_wr_exclusive", 32'(both_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
